// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between NUM_REQ requesters.
// Optional macro ALU_ARB_PRIO0_EN gives requester 0 strict priority over the rotation.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 128,
    parameter int OPW     = 4,
    parameter int SHW     = 5,
    parameter int ALU_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPW-1:0]   req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*SHW-1:0]   req_shift,
    output logic [OPW-1:0]           alu_opcode,
    output logic [WIDTH-1:0]         alu_in1,
    output logic [WIDTH-1:0]         alu_in2,
    output logic [SHW-1:0]           alu_shift,
    input  logic [WIDTH-1:0]         alu_result,
    input  logic [3:0]               alu_flags,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [3:0]               rsp_flags,
    output logic                     busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i];
    // req_ready is the combinational one-hot grant and has no dependence on rsp side.
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant;
    logic               found;
    logic [NUM_REQ-1:0] tag_q [ALU_LAT];
    logic [NUM_REQ-1:0] tag_d [ALU_LAT];
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [3:0]         rsp_flags_q, rsp_flags_d;

    always_comb begin
        grant = '0;
        found = 1'b0;
        if (!hold) begin
`ifdef ALU_ARB_PRIO0_EN
            if (req_valid[0]) begin
                grant[0] = 1'b1;
                found    = 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int k = 1; k < NUM_REQ; k++) begin
                    if (!found && k == (int'(ptr_q) + i) % NUM_REQ && req_valid[k]) begin
                        grant[k] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
`else
            for (int i = 0; i < NUM_REQ; i++) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!found && k == (int'(ptr_q) + i) % NUM_REQ && req_valid[k]) begin
                        grant[k] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
`endif
        end
    end

    assign req_ready = grant;

    always_comb begin
        ptr_d = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                ptr_d = PTR_W'((k + 1) % NUM_REQ);
            end
        end
`ifdef ALU_ARB_PRIO0_EN
        // A priority win by requester 0 must not disturb the rotation among the others.
        if (grant[0]) begin
            ptr_d = ptr_q;
        end
`endif
    end

    always_comb begin
        alu_opcode = '0;
        alu_in1    = '0;
        alu_in2    = '0;
        alu_shift  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                alu_opcode = req_opcode[k*OPW +: OPW];
                alu_in1    = req_a[k*WIDTH +: WIDTH];
                alu_in2    = req_b[k*WIDTH +: WIDTH];
                alu_shift  = req_shift[k*SHW +: SHW];
            end
        end
    end

    // The tag pipe mirrors the ALU's internal registers so the last stage lines up with alu_result.
    always_comb begin
        tag_d[0] = grant;
        for (int s = 1; s < ALU_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
        rsp_valid_d  = tag_q[ALU_LAT-1];
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (|tag_q[ALU_LAT-1]) begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < ALU_LAT; s++) begin
            busy = busy | (|tag_q[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            for (int s = 0; s < ALU_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            for (int s = 0; s < ALU_LAT; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Table-driven bench for alu_rr_arbiter with a two-register ALU model standing in for the real ALU.
// Requester i presents a = row.a + i, b = row.b, opcode = row.op, shift = i + 1.
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 128;
    localparam int OPW     = 4;
    localparam int SHW     = 5;
    localparam int ALU_LAT = 2;

`ifdef ALU_ARB_PRIO0_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     hold;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*OPW-1:0]   req_opcode;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*SHW-1:0]   req_shift;
    logic [OPW-1:0]           alu_opcode;
    logic [WIDTH-1:0]         alu_in1;
    logic [WIDTH-1:0]         alu_in2;
    logic [SHW-1:0]           alu_shift;
    logic [WIDTH-1:0]         alu_result;
    logic [3:0]               alu_flags;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [WIDTH-1:0]         rsp_result;
    logic [3:0]               rsp_flags;
    logic                     busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .OPW(OPW), .SHW(SHW), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    // ALU model: opcode 0 = ADD, 1 = SUB (carry = borrow), others = AND; flags {carry,zero,overflow,sign}
    logic [OPW-1:0]   m_op;
    logic [WIDTH-1:0] m_x, m_y;

    function automatic logic [WIDTH+3:0] alu_fn(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   wide;
        logic [WIDTH-1:0] r;
        logic             c, o;
        c = 1'b0;
        o = 1'b0;
        if (op == 4'd0) begin
            wide = {1'b0, x} + {1'b0, y};
            r    = wide[WIDTH-1:0];
            c    = wide[WIDTH];
            o    = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else if (op == 4'd1) begin
            r = x - y;
            c = (x < y);
            o = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else begin
            r = x & y;
        end
        return {c, (r == '0), o, r[WIDTH-1], r};
    endfunction

    always @(posedge clk) begin
        m_op <= alu_opcode;
        m_x  <= alu_in1;
        m_y  <= alu_in2;
        {alu_flags, alu_result} <= alu_fn(m_op, m_x, m_y);
    end

    typedef struct {
        logic         rst;
        logic         hold;
        logic [3:0]   valid;
        logic [3:0]   op;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [3:0]   exp_ready;
        logic [3:0]   exp_rsp;
        logic         exp_busy;
        logic         chk_res;
        logic [31:0]  exp_res;
        logic [3:0]   exp_flags;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic h, input logic [3:0] valid,
                                input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] exp_ready, input logic [3:0] exp_rsp,
                                input logic exp_busy, input logic chk,
                                input logic [31:0] exp_res, input logic [3:0] exp_flags);
        vec_t v;
        v.rst = r; v.hold = h; v.valid = valid; v.op = op; v.a = a; v.b = b;
        v.exp_ready = exp_ready; v.exp_rsp = exp_rsp; v.exp_busy = exp_busy;
        v.chk_res = chk; v.exp_res = exp_res; v.exp_flags = exp_flags;
        return v;
    endfunction

    // scoreboard compare
    task automatic check(input string name, input int row, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    // driver
    task automatic drive(input vec_t v);
        rst       = v.rst;
        hold      = v.hold;
        req_valid = v.valid;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_opcode[i*OPW +: OPW]   = v.op;
            req_a[i*WIDTH +: WIDTH]    = {96'd0, v.a + 32'(i)};
            req_b[i*WIDTH +: WIDTH]    = {96'd0, v.b};
            req_shift[i*SHW +: SHW]    = SHW'(i + 1);
        end
    endtask

    task automatic build_table();
        logic [31:0] last_res;
        // reset state, then single request from requester 1: 5 + 7
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0010, 0, 4, 7, 4'b0010, 4'b0000, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0010, 0, 1, 12, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 12, 4'b0000));
        // reset re-centres the pointer at 0
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 12, 4'b0000));
        // all four valid for 8 cycles, ADD a=i b=1, then drain
        last_res = 0;
        for (int k = 0; k < 12; k++) begin
            logic [3:0]  er, ep;
            logic        eb, chk;
            logic [31:0] res;
            er  = (k < 8) ? (PRIO ? 4'b0001 : 4'(1 << (k % 4))) : 4'b0000;
            eb  = (k >= 1 && k <= 9);
            ep  = 4'b0000;
            chk = (k == 0) || (k >= 3);
            res = last_res;
            if (k >= 3 && k <= 10) begin
                ep  = PRIO ? 4'b0001 : 4'(1 << ((k - 3) % 4));
                res = PRIO ? 32'd1 : 32'((k - 3) % 4 + 1);
            end
            last_res = res;
            vecs.push_back(mk(0, 0, (k < 8) ? 4'b1111 : 4'b0000, 0, 0, 1, er, ep, eb, chk, res, 4'b0000));
        end
        // requester 2 SUB 3 - 3 gives zero flag
        vecs.push_back(mk(0, 0, 4'b0100, 1, 1, 3, 4'b0100, 4'b0000, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 1, 0, 4'b0100));
        // two ops in flight, then hold: no grants, both retire, busy falls
        vecs.push_back(mk(0, 0, 4'b1000, 0, 0, 5, 4'b1000, 4'b0000, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0001, 0, 0, 5, 4'b0001, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b1000, 1, 1, 8, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 5, 4'b0000));
        vecs.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 5, 4'b0000));
        // requesters 0 and 3 with pointer at 1; the winner drops its request afterwards
        vecs.push_back(mk(0, 0, 4'b1001, 0, 0, 10, PRIO ? 4'b0001 : 4'b1000, 4'b0000, 0, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, PRIO ? 4'b1000 : 4'b0001, 0, 0, 10, PRIO ? 4'b1000 : 4'b0001,
                          4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, PRIO ? 4'b0001 : 4'b1000, 1, 1,
                          PRIO ? 32'd10 : 32'd13, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, PRIO ? 4'b1000 : 4'b0001, 0, 1,
                          PRIO ? 32'd13 : 32'd10, 4'b0000));
        // issue 1 + 1, reset the next cycle: the op must never respond
        vecs.push_back(mk(0, 0, 4'b0001, 0, 1, 1, 4'b0001, 4'b0000, 0, 1,
                          PRIO ? 32'd13 : 32'd10, 4'b0000));
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 0, 4'b0000));
        end
        // pointer is back at 0 after reset
        vecs.push_back(mk(0, 0, 4'b1111, 0, 0, 2, 4'b0001, 4'b0000, 0, 1, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 2, 4'b0000));
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 1, 2, 4'b0000));
    endtask

    initial begin
        vec_t        v;
        int          idx;
        logic [WIDTH-1:0] e_in1, e_in2;
        logic [OPW-1:0]   e_op;
        logic [SHW-1:0]   e_sh;

        build_table();

        // reset block
        drive(mk(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;

        for (int n = 0; n < vecs.size(); n++) begin
            v = vecs[n];
            drive(v);
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v.exp_ready[i]) idx = i;
            end
            e_op  = '0;
            e_in1 = '0;
            e_in2 = '0;
            e_sh  = '0;
            if (idx >= 0) begin
                e_op  = v.op;
                e_in1 = {96'd0, v.a + 32'(idx)};
                e_in2 = {96'd0, v.b};
                e_sh  = SHW'(idx + 1);
            end
            check("req_ready", n, WIDTH'(req_ready), WIDTH'(v.exp_ready));
            check("rsp_valid", n, WIDTH'(rsp_valid), WIDTH'(v.exp_rsp));
            check("busy", n, WIDTH'(busy), WIDTH'(v.exp_busy));
            check("alu_opcode", n, WIDTH'(alu_opcode), WIDTH'(e_op));
            check("alu_in1", n, alu_in1, e_in1);
            check("alu_in2", n, alu_in2, e_in2);
            check("alu_shift", n, WIDTH'(alu_shift), WIDTH'(e_sh));
            if (v.chk_res) begin
                check("rsp_result", n, rsp_result, {96'd0, v.exp_res});
                check("rsp_flags", n, WIDTH'(rsp_flags), WIDTH'(v.exp_flags));
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one pipelined 128-bit ALU between NUM_REQ independent requesters.
- Each cycle, picks at most one requester using round-robin arbitration and issues its operation to the ALU.
- Tracks the in-flight issue through the fixed ALU latency and returns result plus flags to the originating requester.
- Sits between the requester blocks and the ALU instance. The ALU's clk/rst are tied to this block's clk/rst.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 128, operand/result width
- OPW, 4, opcode width
- SHW, 5, shift amount width
- ALU_LAT, 2, cycles from issue to valid ALU result (input register + output register)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- hold  in  1  1 = suppress new grants (drain mode)
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready
- req_opcode  in  NUM_REQ*OPW  flattened opcodes, requester i at [i*OPW +: OPW]
- req_a  in  NUM_REQ*WIDTH  flattened operand 1
- req_b  in  NUM_REQ*WIDTH  flattened operand 2
- req_shift  in  NUM_REQ*SHW  flattened shift amounts
- alu_opcode  out  OPW  to ALU opcode
- alu_in1  out  WIDTH  to ALU input1
- alu_in2  out  WIDTH  to ALU input2
- alu_shift  out  SHW  to ALU shiftValue
- alu_result  in  WIDTH  from ALU result
- alu_flags  in  4  from ALU {carry,zero,overflow,sign}
- rsp_valid  out  NUM_REQ  one-hot response strobe, single cycle
- rsp_result  out  WIDTH  result, shared by all requesters
- rsp_flags  out  4  flags, shared by all requesters
- busy  out  1  any issue in flight

Behaviour:
- Only clk is used. rst is synchronous, active-high, and samples on the rising clk edge.
- Reset values:
  - rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0.
  - Round-robin pointer=0.
  - In-flight tag pipe cleared.
- Grant (combinational):
  - If hold=0, grant the first requester with req_valid set, searching from the pointer upward modulo NUM_REQ.
  - req_ready = grant vector, at most one bit set.
  - With no valid requests or hold=1, req_ready=0.
- Issue:
  - The alu_* outputs are combinational muxes of the granted requester's fields.
  - With no grant they are driven to all-zero (opcode 0).
- Pointer:
  - On a grant to requester k, pointer <= (k+1) mod NUM_REQ.
  - With no grant, pointer holds.
- Tag pipe:
  - ALU_LAT-deep shift register of NUM_REQ-bit one-hot grant vectors.
  - Stage 0 loads the current grant vector (zero if none).
- Response:
  - When the final tag stage is nonzero, rsp_valid = that tag, registered together with rsp_result=alu_result and rsp_flags=alu_flags.
  - Result to the requester appears exactly ALU_LAT+1 cycles after the handshake cycle.
  - rsp_valid is cleared in every cycle without a retiring tag.
  - rsp_result/rsp_flags hold their last value when rsp_valid=0.
- Throughput: one issue per cycle. Back-to-back grants to different or the same requesters are allowed. No response backpressure; requesters must accept rsp_valid.
- busy = OR of all tag stages.
- Flags:
  - Forwarded unmodified.
  - carry/overflow for non-ADD/SUB opcodes are whatever the ALU holds; requesters must ignore them.
- Boundaries:
  - All requesters valid: strict rotation 0,1,2,3,0,...
  - Single requester continuously valid: granted every cycle.
  - hold asserted: in-flight tags still retire, so busy falls to 0 within ALU_LAT+1 cycles.
  - rst mid-operation: all in-flight tags are dropped and no rsp_valid is produced for them.

Optional Feature:
- Macro ALU_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority. If req_valid[0]&&!hold, requester 0 is granted regardless of the pointer, and the pointer is unchanged.
  - Otherwise round-robin runs over 1..NUM_REQ-1.
- Undefined: pure round-robin as above.

Test Plan:
- Reset, then req_valid=4'b0010, opcode=0, a=5, b=7:
  - ready[1]=1 in the same cycle.
  - rsp_valid=4'b0010 exactly 3 cycles later.
  - rsp_result=12, zero flag=0.
- req_valid=4'b1111 held for 8 cycles, each requester issuing ADD with a=i, b=1:
  - Grants are 0,1,2,3,0,1,2,3.
  - Responses follow in the same order with results 1,2,3,4 repeating.
- Requester 2 issues SUB a=3, b=3:
  - rsp_result=0, zero flag=1.
- Requesters 0 and 3 valid with the pointer at 1:
  - Requester 3 is granted first, then requester 0.
  - With ALU_ARB_PRIO0_EN defined, requester 0 is granted first instead.
- hold=1 while 2 ops are in flight:
  - No new grants.
  - Both responses still return.
  - busy goes 1→0.
- rst asserted 1 cycle after issuing a=1, b=1:
  - No rsp_valid ever appears for that op.
  - All outputs read 0 after the next edge.
